// File: rtl/bg_pkg.sv
// Shared definitions for the bank-group input controller: mode codes, FSM states, MSM masks, pair map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bg_pkg;

  typedef enum logic [1:0] {
    MODE_NTT  = 2'd0,
    MODE_MSM  = 2'd1,
    MODE_LOAD = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MSM  = 3'd2,
    ST_NTT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Banks enabled for an MSM read, selected by the latched bg_sel.
  localparam logic [7:0] MSM_MASK_SEL0 = 8'b0101_1010;
  localparam logic [7:0] MSM_MASK_SEL1 = 8'b1010_1010;

  // First bank of the LOAD pair; the second bank is always first + 4.
  // The pointer MSB picks the half of the group the beat lands in.
  function automatic logic [2:0] pair_first(input logic bg_sel, input logic ptr_msb);
    logic [2:0] idx;
    case ({bg_sel, ptr_msb})
      2'b00:   idx = 3'd2;
      2'b01:   idx = 3'd0;
      2'b10:   idx = 3'd3;
      default: idx = 3'd1;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/bg_pair_decode.sv
// Maps {bg_sel, ptr MSB} to the LOAD bank pair: first/second bank indices and their 2-hot mask.
// Latency: combinational.
// Backpressure: none.
// Ports: bg_sel, ptr_msb in; first_idx (gets upper data half), second_idx, pair_mask out.
module bg_pair_decode
  import bg_pkg::*;
(
  input  logic       bg_sel,
  input  logic       ptr_msb,
  output logic [2:0] first_idx,
  output logic [2:0] second_idx,
  output logic [7:0] pair_mask
);

  always_comb begin
    first_idx  = pair_first(bg_sel, ptr_msb);
    second_idx = first_idx + 3'd4;
    pair_mask  = (8'd1 << first_idx) | (8'd1 << second_idx);
  end

endmodule

// File: rtl/bg_input_ctrl.sv
// Sequenced front-end for one 8-bank group: arbitrates LOAD bursts, MSM reads and NTT reads onto bank ports.
// Latency: bank outputs, done_o and abort_o registered, 1 cycle after the accepted input.
// Backpressure: load_ready_o high only in LOAD; MSM/NTT requests are taken every cycle, none stalled.
// Ports: clk/rst; start_i/mode_i/stop_i command; bg_sel_i/base_addr_i/len_i burst setup;
//        load_valid_i/load_ready_o/load_data_i beats; msm_req_i/msm_addr_i; ntt_addr_i/ntt_ce_i;
//        busy_o/done_o/abort_o status; addr_o/ce_o/wen_o/dout_o bank ports.
module bg_input_ctrl
  import bg_pkg::*;
#(
  parameter int NUM_BANK  = 8,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 256,
  parameter int NTT_PORTS = 4,
  parameter int NTT_AW    = 9,
  parameter int LEN_W     = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [1:0]                    mode_i,
  input  logic                          stop_i,
  input  logic                          bg_sel_i,
  input  logic [ADDR_W:0]               base_addr_i,
  input  logic [LEN_W-1:0]              len_i,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  input  logic [2*DATA_W-1:0]           load_data_i,
  input  logic                          msm_req_i,
  input  logic [ADDR_W-1:0]             msm_addr_i,
  input  logic [NTT_PORTS*NTT_AW-1:0]   ntt_addr_i,
  input  logic [NUM_BANK-1:0]           ntt_ce_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          abort_o,
  output logic [NUM_BANK*ADDR_W-1:0]    addr_o,
  output logic [NUM_BANK-1:0]           ce_o,
  output logic [NUM_BANK-1:0]           wen_o,
  output logic [NUM_BANK*DATA_W-1:0]    dout_o
);

  // The pair map and MSM masks are written for exactly eight banks.
  if (NUM_BANK != 8) begin : g_bad_num_bank
    $error("bg_input_ctrl: NUM_BANK must be 8");
  end

  state_e             state_q, state_d;
  logic               bg_sel_q;
  logic [ADDR_W:0]    ptr_q;
  logic [LEN_W-1:0]   rem_q;

  logic               beat, last_beat;
  logic [2:0]         first_idx, second_idx;
  logic [7:0]         pair_mask;

  logic [NUM_BANK*ADDR_W-1:0] addr_d;
  logic [NUM_BANK-1:0]        ce_d, wen_d;
  logic [NUM_BANK*DATA_W-1:0] dout_d;
  logic                       done_d, abort_d;

  // Only the low ADDR_W bits of each NTT port reach the banks.
  logic ntt_addr_unused;
  assign ntt_addr_unused = ^ntt_addr_i;

  assign load_ready_o = (state_q == ST_LOAD);
  assign busy_o       = (state_q != ST_IDLE);
  assign beat         = load_ready_o && load_valid_i;
  assign last_beat    = beat && (rem_q == LEN_W'(1));

  bg_pair_decode u_pair_decode (
    .bg_sel     (bg_sel_q),
    .ptr_msb    (ptr_q[ADDR_W]),
    .first_idx  (first_idx),
    .second_idx (second_idx),
    .pair_mask  (pair_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bg_sel_q <= 1'b0;
      ptr_q    <= '0;
      rem_q    <= '0;
      addr_o   <= '0;
      ce_o     <= '0;
      wen_o    <= '0;
      dout_o   <= '0;
      done_o   <= 1'b0;
      abort_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_o  <= addr_d;
      ce_o    <= ce_d;
      wen_o   <= wen_d;
      dout_o  <= dout_d;
      done_o  <= done_d;
      abort_o <= abort_d;
      if (state_q == ST_IDLE && start_i) begin
        bg_sel_q <= bg_sel_i;
        ptr_q    <= base_addr_i;
        rem_q    <= len_i;
      end else if (beat) begin
        ptr_q <= ptr_q + 1'b1;
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    ce_d    = '0;
    wen_d   = '0;
    dout_d  = '0;
    abort_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (mode_e'(mode_i))
            MODE_LOAD: state_d = (len_i == '0) ? ST_DONE : ST_LOAD;
            MODE_MSM:  state_d = ST_MSM;
            MODE_NTT:  state_d = ST_NTT;
            default:   state_d = ST_IDLE;
          endcase
        end
      end

      ST_LOAD: begin
        // A beat coincident with stop_i is still written; the abort follows with done.
        if (beat) begin
          ce_d  = pair_mask;
          wen_d = pair_mask;
          for (int b = 0; b < NUM_BANK; b++) begin
            if (pair_mask[b]) addr_d[b*ADDR_W +: ADDR_W] = ptr_q[ADDR_W-1:0];
          end
          dout_d[int'(first_idx)*DATA_W +: DATA_W]  = load_data_i[2*DATA_W-1 -: DATA_W];
          dout_d[int'(second_idx)*DATA_W +: DATA_W] = load_data_i[DATA_W-1:0];
        end
        if (last_beat) begin
          state_d = ST_DONE;
        end else if (stop_i) begin
          state_d = ST_DONE;
          abort_d = 1'b1;
        end
      end

      ST_MSM: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (msm_req_i) begin
          ce_d = bg_sel_q ? MSM_MASK_SEL1 : MSM_MASK_SEL0;
          for (int b = 0; b < NUM_BANK; b++) begin
            if (ce_d[b]) addr_d[b*ADDR_W +: ADDR_W] = msm_addr_i;
          end
        end
      end

      ST_NTT: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else begin
          ce_d = ntt_ce_i;
          for (int b = 0; b < NUM_BANK; b++) begin
            addr_d[b*ADDR_W +: ADDR_W] = ntt_addr_i[(b % NTT_PORTS)*NTT_AW +: ADDR_W];
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_bg_input_ctrl.sv
module tb_bg_input_ctrl;
  localparam int NB = 8, AW = 7, DW = 256, NP = 4, NAW = 9, LW = 9;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, bg_sel, load_valid, msm_req;
  logic [1:0] mode;
  logic [AW:0] base_addr;
  logic [LW-1:0] len;
  logic [2*DW-1:0] load_data;
  logic [AW-1:0] msm_addr;
  logic [NP*NAW-1:0] ntt_addr;
  logic [NB-1:0] ntt_ce;
  logic load_ready_o, busy_o, done_o, abort_o;
  logic [NB*AW-1:0] addr_o;
  logic [NB-1:0] ce_o, wen_o;
  logic [NB*DW-1:0] dout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bg_input_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .stop_i(stop), .bg_sel_i(bg_sel),
    .base_addr_i(base_addr), .len_i(len), .load_valid_i(load_valid), .load_ready_o(load_ready_o),
    .load_data_i(load_data), .msm_req_i(msm_req), .msm_addr_i(msm_addr), .ntt_addr_i(ntt_addr),
    .ntt_ce_i(ntt_ce), .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o), .addr_o(addr_o),
    .ce_o(ce_o), .wen_o(wen_o), .dout_o(dout_o)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] up_dat(input int i);
    return {8{32'hCAFE_0000 + 32'(i)}};
  endfunction

  function automatic logic [DW-1:0] lo_dat(input int i);
    return {8{32'h5EED_0000 + 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bank port check: ce/wen masks, per-bank address (a on enabled banks, else 0),
  // per-bank data (upper to bank f, lower to bank s, 0 elsewhere; f/s = -1 for none).
  task automatic chk_banks(input string tag, input logic [7:0] ce_exp, input logic [7:0] wen_exp,
                           input logic [AW-1:0] a, input int f, input logic [DW-1:0] up,
                           input int s, input logic [DW-1:0] lo);
    logic [DW-1:0] d_exp;
    chk_v({tag, ".ce"}, DW'(ce_o), DW'(ce_exp));
    chk_v({tag, ".wen"}, DW'(wen_o), DW'(wen_exp));
    for (int b = 0; b < NB; b++) begin
      chk_v($sformatf("%s.addr%0d", tag, b), DW'(addr_o[b*AW +: AW]), DW'(ce_exp[b] ? a : 7'h00));
      d_exp = (b == f) ? up : ((b == s) ? lo : '0);
      chk_v($sformatf("%s.dout%0d", tag, b), dout_o[b*DW +: DW], d_exp);
    end
  endtask

  task automatic chk_idle_out(input string tag);
    chk_v({tag, ".ce"}, DW'(ce_o), '0);
    chk_v({tag, ".wen"}, DW'(wen_o), '0);
    chk_b({tag, ".addr_zero"}, |addr_o, 1'b0);
    chk_b({tag, ".dout_zero"}, |dout_o, 1'b0);
  endtask

  // Hand-computed LOAD vectors.
  logic [7:0]    t1_ce [4] = '{8'h44, 8'h44, 8'h11, 8'h11};
  logic [AW-1:0] t1_a  [4] = '{7'h7E, 7'h7F, 7'h00, 7'h01};
  int            t1_f  [4] = '{2, 2, 0, 0};
  int            t1_s  [4] = '{6, 6, 4, 4};
  logic [7:0]    t3_ce [3] = '{8'h22, 8'h88, 8'h88};
  logic [AW-1:0] t3_a  [3] = '{7'h7F, 7'h00, 7'h01};
  int            t3_f  [3] = '{1, 3, 3};
  int            t3_s  [3] = '{5, 7, 7};
  logic [AW-1:0] t5_a  [8] = '{7'h23, 7'h42, 7'h7F, 7'h00, 7'h23, 7'h42, 7'h7F, 7'h00};

  initial begin
    rst = 1'b1; start = 0; stop = 0; bg_sel = 0; load_valid = 0; msm_req = 0; mode = 2'd0;
    base_addr = '0; len = '0; load_data = '0; msm_addr = '0; ntt_addr = '0; ntt_ce = '0;
    tick(); tick();

    // Reset state
    chk_idle_out("rst");
    chk_b("rst.busy", busy_o, 1'b0);
    chk_b("rst.done", done_o, 1'b0);
    chk_b("rst.abort", abort_o, 1'b0);
    chk_b("rst.ready", load_ready_o, 1'b0);
    rst = 1'b0;
    tick();

    // 1: LOAD bg_sel=0 base=0x7E len=4, valid every cycle, pointer crosses the half boundary
    bg_sel = 0; base_addr = 8'h7E; len = 9'd4; mode = 2'd2; start = 1;
    tick();
    start = 0;
    chk_b("t1.busy", busy_o, 1'b1);
    chk_b("t1.ready", load_ready_o, 1'b1);
    chk_v("t1.ce_pre", DW'(ce_o), '0);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = {up_dat(i), lo_dat(i)};
      tick();
      chk_banks($sformatf("t1.beat%0d", i), t1_ce[i], t1_ce[i], t1_a[i], t1_f[i], up_dat(i), t1_s[i], lo_dat(i));
      chk_b($sformatf("t1.done%0d", i), done_o, (i == 3) ? 1'b1 : 1'b0);
      chk_b($sformatf("t1.abort%0d", i), abort_o, 1'b0);
    end
    load_valid = 0;
    tick();
    chk_b("t1.done_end", done_o, 1'b0);
    chk_b("t1.busy_end", busy_o, 1'b0);
    chk_idle_out("t1.end");

    // 2: LOAD len=3 bg_sel=1 base=0x10, valid 1,0,1,0,1
    bg_sel = 1; base_addr = 8'h10; len = 9'd3; mode = 2'd2; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = (i % 2 == 0); load_data = {up_dat(10 + i / 2), lo_dat(10 + i / 2)};
      tick();
      if (i % 2 == 0)
        chk_banks($sformatf("t2.step%0d", i), 8'h88, 8'h88, AW'(7'h10 + i / 2), 3, up_dat(10 + i / 2), 7, lo_dat(10 + i / 2));
      else
        chk_idle_out($sformatf("t2.step%0d", i));
      chk_b($sformatf("t2.done%0d", i), done_o, (i == 4) ? 1'b1 : 1'b0);
    end
    load_valid = 0;
    tick();
    chk_b("t2.busy_end", busy_o, 1'b0);

    // 3: LOAD len=8 bg_sel=1 base=0xFF, stop_i with beat 2
    bg_sel = 1; base_addr = 8'hFF; len = 9'd8; mode = 2'd2; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = {up_dat(20 + i), lo_dat(20 + i)}; stop = (i == 2);
      tick();
      chk_banks($sformatf("t3.beat%0d", i), t3_ce[i], t3_ce[i], t3_a[i], t3_f[i], up_dat(20 + i), t3_s[i], lo_dat(20 + i));
      chk_b($sformatf("t3.done%0d", i), done_o, (i == 2) ? 1'b1 : 1'b0);
      chk_b($sformatf("t3.abort%0d", i), abort_o, (i == 2) ? 1'b1 : 1'b0);
    end
    stop = 0; load_valid = 0;
    tick();
    chk_b("t3.busy_end", busy_o, 1'b0);
    chk_b("t3.done_end", done_o, 1'b0);
    chk_b("t3.abort_end", abort_o, 1'b0);
    chk_idle_out("t3.end");

    // Reserved mode: start ignored
    mode = 2'd3; start = 1;
    tick();
    start = 0;
    chk_b("rsvd.busy", busy_o, 1'b0);

    // 4: MSM bg_sel=1 addr=0x15
    bg_sel = 1; mode = 2'd1; start = 1;
    tick();
    start = 0;
    chk_b("t4.busy", busy_o, 1'b1);
    chk_b("t4.ready", load_ready_o, 1'b0);
    msm_req = 1; msm_addr = 7'h15;
    tick();
    chk_banks("t4.req", 8'hAA, 8'h00, 7'h15, -1, '0, -1, '0);
    msm_req = 0;
    tick();
    chk_idle_out("t4.noreq");
    msm_req = 1; stop = 1;
    tick();
    chk_idle_out("t4.stop");
    chk_b("t4.busy_stop", busy_o, 1'b0);
    msm_req = 0; stop = 0;

    // MSM with bg_sel=0 uses the other mask
    bg_sel = 0; mode = 2'd1; start = 1;
    tick();
    start = 0; msm_req = 1; msm_addr = 7'h2C;
    tick();
    chk_banks("t4b.req", 8'h5A, 8'h00, 7'h2C, -1, '0, -1, '0);
    msm_req = 0; stop = 1;
    tick();
    stop = 0;

    // 5: NTT address fan-out
    mode = 2'd0; start = 1;
    tick();
    start = 0;
    ntt_addr = {9'h100, 9'h0FF, 9'h042, 9'h1A3}; ntt_ce = 8'hFF;
    tick();
    chk_v("t5.ce", DW'(ce_o), DW'(8'hFF));
    chk_v("t5.wen", DW'(wen_o), '0);
    for (int b = 0; b < NB; b++)
      chk_v($sformatf("t5.addr%0d", b), DW'(addr_o[b*AW +: AW]), DW'(t5_a[b]));
    // start while busy is ignored
    ntt_ce = 8'h0F; start = 1; mode = 2'd2;
    tick();
    start = 0;
    chk_v("t5.ce2", DW'(ce_o), DW'(8'h0F));
    chk_b("t5.ready_busy", load_ready_o, 1'b0);
    stop = 1;
    tick();
    stop = 0;
    chk_b("t5.busy_stop", busy_o, 1'b0);
    chk_v("t5.ce_stop", DW'(ce_o), '0);
    ntt_ce = '0;

    // 6: reset mid-LOAD, then len=0 start
    bg_sel = 0; base_addr = 8'h00; len = 9'd8; mode = 2'd2; start = 1;
    tick();
    start = 0; load_valid = 1; load_data = {up_dat(30), lo_dat(30)};
    tick();
    chk_v("t6.ce_pre", DW'(ce_o), DW'(8'h44));
    #2 rst = 1'b1;
    #1;
    chk_idle_out("t6.rst");
    chk_b("t6.busy_rst", busy_o, 1'b0);
    tick();
    chk_b("t6.done_rst", done_o, 1'b0);
    chk_b("t6.abort_rst", abort_o, 1'b0);
    rst = 1'b0; load_valid = 0;
    tick();
    chk_b("t6.busy_after", busy_o, 1'b0);
    chk_b("t6.done_after", done_o, 1'b0);

    len = 9'd0; mode = 2'd2; start = 1;
    tick();
    chk_b("t6.len0_done", done_o, 1'b1);
    chk_b("t6.len0_abort", abort_o, 1'b0);
    chk_b("t6.len0_busy", busy_o, 1'b1);
    chk_idle_out("t6.len0");
    // start held through DONE (now MSM) must be ignored
    mode = 2'd1;
    tick();
    start = 0;
    chk_b("t6.done_clr", done_o, 1'b0);
    chk_b("t6.start_in_done", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
